// File: rtl/ycbcr_coef_ctrl.sv
// Purpose: shadow/active coefficient banks for the RGB-to-YCbCr converter, applied on a frame boundary.
// Latency: active bank and o_update_done change one edge after the vs_rise (or timeout) cycle; readback is 1 cycle.
// Backpressure: none; writes, presets and commits are accepted every cycle (a commit while pending is dropped).
//
// Ports:
//   clk, rst                  pixel clock, synchronous active-high reset
//   i_v_sync                  vertical sync; its rising edge marks the frame boundary
//   i_wr_en/addr/data         shadow write (addr 0-8 coefs, 9 Y offset, 10 C offset)
//   i_preset_load/sel         overwrite shadow with BT.601 (0) or BT.709 (1) limited-range preset
//   i_commit                  request shadow-to-active transfer at the next frame boundary
//   i_rd_addr/i_rd_active     readback select; o_rd_data registered, zero-extended
//   o_coef_*_10b, o_ofs_*_18b active bank
//   o_pending, o_update_done, o_update_forced  status
module ycbcr_coef_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 4000000,
  parameter int unsigned CNT_W          = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_v_sync,
  input  logic        i_wr_en,
  input  logic [3:0]  i_wr_addr,
  input  logic [17:0] i_wr_data,
  input  logic        i_preset_load,
  input  logic        i_preset_sel,
  input  logic        i_commit,
  input  logic [3:0]  i_rd_addr,
  input  logic        i_rd_active,
  output logic [17:0] o_rd_data,
  output logic [9:0]  o_coef_y_r_10b,
  output logic [9:0]  o_coef_y_g_10b,
  output logic [9:0]  o_coef_y_b_10b,
  output logic [9:0]  o_coef_cb_r_10b,
  output logic [9:0]  o_coef_cb_g_10b,
  output logic [9:0]  o_coef_cb_b_10b,
  output logic [9:0]  o_coef_cr_r_10b,
  output logic [9:0]  o_coef_cr_g_10b,
  output logic [9:0]  o_coef_cr_b_10b,
  output logic [17:0] o_ofs_y_18b,
  output logic [17:0] o_ofs_c_18b,
  output logic        o_pending,
  output logic        o_update_done,
  output logic        o_update_forced
);

  localparam int NUM_REGS = 11;
  localparam int NUM_COEF = 9;

  localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST  =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t            state_q, state_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              vs_d;
  logic              vs_rise;
  logic              apply;
  logic              apply_forced;

  // All entries stored as 18b words; coefficient entries keep [17:10] at zero
  // so readback zero-extension falls out of the storage format.
  logic [17:0] sh_q  [NUM_REGS];
  logic [17:0] act_q [NUM_REGS];

  // sel709: 1 = BT.709 limited, 0 = BT.601 limited
  function automatic logic [17:0] preset_val(input logic sel709, input logic [3:0] idx);
    logic [17:0] v;
    v = '0;
    case (idx)
      4'd0:    v = sel709 ? 18'd47  : 18'd66;
      4'd1:    v = sel709 ? 18'd157 : 18'd129;
      4'd2:    v = sel709 ? 18'd16  : 18'd25;
      4'd3:    v = sel709 ? 18'd26  : 18'd38;
      4'd4:    v = sel709 ? 18'd86  : 18'd74;
      4'd5:    v = 18'd112;
      4'd6:    v = 18'd112;
      4'd7:    v = sel709 ? 18'd102 : 18'd94;
      4'd8:    v = sel709 ? 18'd10  : 18'd18;
      4'd9:    v = 18'd4096;
      4'd10:   v = 18'd32768;
      default: v = '0;
    endcase
    return v;
  endfunction

  assign vs_rise = i_v_sync & ~vs_d;

  // Next-state: a frame edge seen in IDLE is deliberately ignored, even when
  // it coincides with the commit, so the apply always lands on a later frame.
  always_comb begin
    state_nxt    = state_q;
    cnt_nxt      = cnt_q;
    apply        = 1'b0;
    apply_forced = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_commit) begin
          state_nxt = ST_PENDING;
          cnt_nxt   = '0;
        end
      end
      ST_PENDING: begin
        if (vs_rise || (TIMEOUT_EN && (cnt_q == CNT_LAST))) begin
          apply        = 1'b1;
          apply_forced = ~vs_rise;
          state_nxt    = ST_IDLE;
          cnt_nxt      = '0;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      vs_d            <= 1'b0;
      o_pending       <= 1'b0;
      o_update_done   <= 1'b0;
      o_update_forced <= 1'b0;
    end else begin
      state_q         <= state_nxt;
      cnt_q           <= cnt_nxt;
      vs_d            <= i_v_sync;
      o_pending       <= (state_nxt == ST_PENDING);
      o_update_done   <= apply;
      o_update_forced <= apply_forced;
    end
  end

  // Banks. The active copy takes the shadow value as it stood before this
  // edge, so a write or preset in the apply cycle only reaches the shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        sh_q[i]  <= preset_val(1'b1, 4'(i));
        act_q[i] <= preset_val(1'b1, 4'(i));
      end
    end else begin
      if (i_preset_load) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          sh_q[i] <= preset_val(i_preset_sel, 4'(i));
        end
      end else if (i_wr_en && (i_wr_addr < 4'(NUM_REGS))) begin
        if (i_wr_addr < 4'(NUM_COEF)) begin
          sh_q[i_wr_addr] <= {8'd0, i_wr_data[9:0]};
        end else begin
          sh_q[i_wr_addr] <= i_wr_data;
        end
      end
      if (apply) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          act_q[i] <= sh_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_rd_data <= '0;
    end else if (i_rd_addr < 4'(NUM_REGS)) begin
      o_rd_data <= i_rd_active ? act_q[i_rd_addr] : sh_q[i_rd_addr];
    end else begin
      o_rd_data <= '0;
    end
  end

  assign o_coef_y_r_10b  = act_q[0][9:0];
  assign o_coef_y_g_10b  = act_q[1][9:0];
  assign o_coef_y_b_10b  = act_q[2][9:0];
  assign o_coef_cb_r_10b = act_q[3][9:0];
  assign o_coef_cb_g_10b = act_q[4][9:0];
  assign o_coef_cb_b_10b = act_q[5][9:0];
  assign o_coef_cr_r_10b = act_q[6][9:0];
  assign o_coef_cr_g_10b = act_q[7][9:0];
  assign o_coef_cr_b_10b = act_q[8][9:0];
  assign o_ofs_y_18b     = act_q[9];
  assign o_ofs_c_18b     = act_q[10];

endmodule

// File: tb/tb_ycbcr_coef_ctrl.sv
// Testbench for ycbcr_coef_ctrl: directed frame/commit scenarios followed by
// random traffic, scored against a bank-level reference model.
module tb_ycbcr_coef_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_v_sync = 1'b0;
  logic        i_wr_en = 1'b0;
  logic [3:0]  i_wr_addr = '0;
  logic [17:0] i_wr_data = '0;
  logic        i_preset_load = 1'b0;
  logic        i_preset_sel = 1'b0;
  logic        i_commit = 1'b0;
  logic [3:0]  i_rd_addr = '0;
  logic        i_rd_active = 1'b0;
  logic [17:0] o_rd_data;
  logic [9:0]  o_coef_y_r_10b, o_coef_y_g_10b, o_coef_y_b_10b;
  logic [9:0]  o_coef_cb_r_10b, o_coef_cb_g_10b, o_coef_cb_b_10b;
  logic [9:0]  o_coef_cr_r_10b, o_coef_cr_g_10b, o_coef_cr_b_10b;
  logic [17:0] o_ofs_y_18b, o_ofs_c_18b;
  logic        o_pending, o_update_done, o_update_forced;

  ycbcr_coef_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .i_v_sync(i_v_sync),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_preset_load(i_preset_load), .i_preset_sel(i_preset_sel),
    .i_commit(i_commit), .i_rd_addr(i_rd_addr), .i_rd_active(i_rd_active),
    .o_rd_data(o_rd_data),
    .o_coef_y_r_10b(o_coef_y_r_10b), .o_coef_y_g_10b(o_coef_y_g_10b), .o_coef_y_b_10b(o_coef_y_b_10b),
    .o_coef_cb_r_10b(o_coef_cb_r_10b), .o_coef_cb_g_10b(o_coef_cb_g_10b), .o_coef_cb_b_10b(o_coef_cb_b_10b),
    .o_coef_cr_r_10b(o_coef_cr_r_10b), .o_coef_cr_g_10b(o_coef_cr_g_10b), .o_coef_cr_b_10b(o_coef_cr_b_10b),
    .o_ofs_y_18b(o_ofs_y_18b), .o_ofs_c_18b(o_ofs_c_18b),
    .o_pending(o_pending), .o_update_done(o_update_done), .o_update_forced(o_update_forced)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [197:0] got, input logic [197:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [17:0]  rd;
    logic         pend;
    logic         done;
    logic         forced;
    logic [197:0] act;
  } exp_t;

  exp_t q[$];

  int unsigned m_sh[11];
  int unsigned m_act[11];
  bit          m_pend;
  int          m_waited;   // PENDING cycles already elapsed before this one
  bit          m_vs_prev;

  function automatic int unsigned preset(input bit bt709, input int idx);
    case (idx)
      0: return bt709 ? 47  : 66;
      1: return bt709 ? 157 : 129;
      2: return bt709 ? 16  : 25;
      3: return bt709 ? 26  : 38;
      4: return bt709 ? 86  : 74;
      5: return 112;
      6: return 112;
      7: return bt709 ? 102 : 94;
      8: return bt709 ? 10  : 18;
      9: return 4096;
      10: return 32768;
      default: return 0;
    endcase
  endfunction

  function automatic logic [197:0] pack_model();
    logic [197:0] v;
    v = '0;
    for (int i = 0; i < 11; i++) v[i*18 +: 18] = 18'(m_act[i]);
    return v;
  endfunction

  function automatic logic [197:0] pack_dut();
    logic [197:0] v;
    v = {o_ofs_c_18b, o_ofs_y_18b,
         8'd0, o_coef_cr_b_10b, 8'd0, o_coef_cr_g_10b, 8'd0, o_coef_cr_r_10b,
         8'd0, o_coef_cb_b_10b, 8'd0, o_coef_cb_g_10b, 8'd0, o_coef_cb_r_10b,
         8'd0, o_coef_y_b_10b,  8'd0, o_coef_y_g_10b,  8'd0, o_coef_y_r_10b};
    return v;
  endfunction

  // Predicts the outputs seen after the coming clock edge from the inputs now applied.
  task automatic model_step();
    exp_t e;
    bit   frame_edge;
    e.done   = 1'b0;
    e.forced = 1'b0;
    if (rst) begin
      for (int i = 0; i < 11; i++) begin
        m_sh[i]  = preset(1'b1, i);
        m_act[i] = preset(1'b1, i);
      end
      m_pend    = 1'b0;
      m_waited  = 0;
      m_vs_prev = 1'b0;
      e.rd      = '0;
    end else begin
      if (i_rd_addr < 11) e.rd = 18'(i_rd_active ? m_act[i_rd_addr] : m_sh[i_rd_addr]);
      else                e.rd = '0;
      frame_edge = i_v_sync && !m_vs_prev;
      if (m_pend) begin
        if (frame_edge || m_waited == TO - 1) begin
          m_act    = m_sh;
          e.done   = 1'b1;
          e.forced = !frame_edge;
          m_pend   = 1'b0;
        end else begin
          m_waited++;
        end
      end else if (i_commit) begin
        m_pend   = 1'b1;
        m_waited = 0;
      end
      if (i_preset_load) begin
        for (int i = 0; i < 11; i++) m_sh[i] = preset(i_preset_sel, i);
      end else if (i_wr_en && i_wr_addr < 11) begin
        m_sh[i_wr_addr] = (i_wr_addr < 9) ? int'(i_wr_data[9:0]) : int'(i_wr_data);
      end
      m_vs_prev = i_v_sync;
    end
    e.pend = m_pend;
    e.act  = pack_model();
    q.push_back(e);
  endtask

  // One cycle: inputs already driven at this negedge; predict, then advance.
  task automatic step();
    model_step();
    @(negedge clk);
    i_wr_en       = 1'b0;
    i_preset_load = 1'b0;
    i_commit      = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rd_data",  o_rd_data,       e.rd);
        chk("pending",  o_pending,       e.pend);
        chk("upd_done", o_update_done,   e.done);
        chk("forced",   o_update_forced, e.forced);
        chk("active",   pack_dut(),      e.act);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);
    rst = 1'b1;
    repeat (3) step();
    chk("rst_y_g",   o_coef_y_g_10b, 157);
    chk("rst_ofs_c", o_ofs_c_18b,    32768);
    chk("rst_pend",  o_pending,      0);
    rst = 1'b0;

    // active readback of CB_G
    i_rd_addr = 4'd4; i_rd_active = 1'b1;
    step();
    chk("rd_act4", o_rd_data, 86);

    // BT.601 preset applied on a frame edge
    i_preset_load = 1'b1; i_preset_sel = 1'b0; step();
    i_commit = 1'b1; step();
    step(); step();
    chk("hold_y_r", o_coef_y_r_10b, 47);
    i_v_sync = 1'b1; step();
    chk("vs_y_r",    o_coef_y_r_10b, 66);
    chk("vs_cr_b",   o_coef_cr_b_10b, 18);
    chk("vs_done",   o_update_done, 1);
    chk("vs_forced", o_update_forced, 0);
    chk("vs_pend",   o_pending, 0);
    i_v_sync = 1'b0;

    // timeout apply
    i_wr_en = 1'b1; i_wr_addr = 4'd1; i_wr_data = 18'd200; step();
    i_commit = 1'b1; step();
    repeat (TO - 1) step();
    chk("to_early_done", o_update_done, 0);
    step();
    chk("to_y_g",   o_coef_y_g_10b, 200);
    chk("to_done",  o_update_done, 1);
    chk("to_force", o_update_forced, 1);

    // commit coinciding with a frame edge in IDLE
    i_commit = 1'b1; i_v_sync = 1'b1; step();
    chk("cv_pend", o_pending, 1);
    chk("cv_done", o_update_done, 0);
    step();
    i_v_sync = 1'b0; step();
    i_v_sync = 1'b1; step();
    chk("cv2_done",   o_update_done, 1);
    chk("cv2_forced", o_update_forced, 0);

    // write on the apply cycle
    i_v_sync = 1'b0; step();
    i_commit = 1'b1; step();
    i_v_sync = 1'b1; i_wr_en = 1'b1; i_wr_addr = 4'd9; i_wr_data = 18'd5000; step();
    chk("wa_ofs_y", o_ofs_y_18b, 4096);
    i_v_sync = 1'b0; i_rd_active = 1'b0; i_rd_addr = 4'd9; step();
    chk("wa_rd_sh", o_rd_data, 5000);

    // reset while pending
    i_commit = 1'b1; step();
    step();
    rst = 1'b1; step();
    chk("rp_pend", o_pending, 0);
    chk("rp_done", o_update_done, 0);
    chk("rp_y_g",  o_coef_y_g_10b, 157);
    rst = 1'b0; step();
    i_v_sync = 1'b1; step();
    chk("rp_vs_done", o_update_done, 0);
    chk("rp_vs_y_g",  o_coef_y_g_10b, 157);

    // out-of-range write and read
    i_v_sync = 1'b0;
    i_wr_en = 1'b1; i_wr_addr = 4'd12; i_wr_data = 18'd99; step();
    i_rd_active = 1'b0; i_rd_addr = 4'd12; step();
    chk("oor_rd", o_rd_data, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) i_v_sync = ~i_v_sync;
      i_wr_en       = ($urandom_range(0, 3) == 0);
      i_wr_addr     = 4'($urandom_range(0, 15));
      i_wr_data     = 18'($urandom);
      i_preset_load = ($urandom_range(0, 19) == 0);
      i_preset_sel  = 1'($urandom_range(0, 1));
      i_commit      = ($urandom_range(0, 7) == 0);
      i_rd_addr     = 4'($urandom_range(0, 15));
      i_rd_active   = 1'($urandom_range(0, 1));
      step();
    end
    rst = 1'b0;

    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
    chk("drain", 198'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
